// File: rtl/cmd_memory_banked.sv
// cmd_memory_banked
//   Parses lines of the form "NN <text>\r" popped from the UART RX FIFO into
//   NUM_BANKS independent command tables of CMD_DEPTH rows x CMD_WIDTH bytes.
//   A line's text is staged and written as a whole row in one COMMIT cycle,
//   so a line that errors out never touches the table. "CR" clears the count
//   of the latched bank, "CA" clears every bank.
//
// Ports
//   clk, rst       single clock, synchronous active-high reset
//   enable         programming mode; low stops new FIFO pops and aborts a line
//   data_ready     RX FIFO not empty
//   rd_en          one-cycle pop request (at most one read outstanding)
//   data_valid     cmd_data valid, one cycle after rd_en
//   cmd_data       byte from the FIFO
//   wr_bank        target bank, latched on the first byte of each line
//   rd_bank        read-port bank select
//   rd_addr        0 = command count, 1+i*CMD_WIDTH+j = byte j of command i
//   rd_data        registered read data (latency 1)
//   busy           parser not idle
//   cmd_written    one-cycle pulse on a successful commit
//   error_pulse    one-cycle error strobe
//   error_code     last error code, held until the next error
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for the first byte of a line, CR/LF are skipped
// S_ADDR_LO | first digit held, waiting for the second address digit
// S_SPACE   | address accepted, expecting the separating space
// S_TEXT    | collecting text bytes into the staging row until CR
// S_COMMIT  | one cycle: staging row written to the table
// S_GOT_C   | 'C' seen, expecting 'R' (clear bank) or 'A' (clear all)
// S_DISCARD | errored line, dropping bytes up to and including LF
module cmd_memory_banked #(
    parameter int CMD_WIDTH = 32,
    parameter int CMD_DEPTH = 16,
    parameter int NUM_BANKS = 2,
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int AW = $clog2(CMD_DEPTH * CMD_WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          data_ready,
    output logic          rd_en,
    input  logic          data_valid,
    input  logic [7:0]    cmd_data,
    input  logic [BW-1:0] wr_bank,
    input  logic [BW-1:0] rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          busy,
    output logic          cmd_written,
    output logic          error_pulse,
    output logic [2:0]    error_code
);

    localparam int ROWS = NUM_BANKS * CMD_DEPTH;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW   = $clog2(CMD_DEPTH + 1);
    localparam int LW   = $clog2(CMD_WIDTH + 1);
    localparam int JW   = (CMD_WIDTH > 1) ? $clog2(CMD_WIDTH) : 1;

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_C     = 8'h43;
    localparam logic [7:0] CH_R     = 8'h52;
    localparam logic [7:0] CH_A     = 8'h41;

    localparam logic [2:0] ERR_WIDE  = 3'd1;
    localparam logic [2:0] ERR_ADDR  = 3'd2;
    localparam logic [2:0] ERR_SPACE = 3'd3;
    localparam logic [2:0] ERR_FULL  = 3'd4;
    localparam logic [2:0] ERR_CMD   = 3'd5;
    localparam logic [2:0] ERR_EMPTY = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_LO,
        S_SPACE,
        S_TEXT,
        S_COMMIT,
        S_GOT_C,
        S_DISCARD
    } state_t;

    state_t state, state_next;

    logic [CMD_WIDTH-1:0][7:0] mem [ROWS];
    logic [CMD_WIDTH-1:0][7:0] stage;
    logic [LW-1:0]             len;
    logic [CW-1:0]             count [NUM_BANKS];
    logic [BW-1:0]             bank_q;
    logic [3:0]                d1;
    logic [6:0]                nn;
    logic                      pending;

    logic       byte_take;
    logic       is_digit;
    logic [6:0] nn_calc;
    logic [CW-1:0] cur_count;
    logic [RW-1:0] commit_row;

    logic       err_set;
    logic [2:0] err_val;
    logic       lat_bank;
    logic       st_d1;
    logic       st_nn;
    logic       line_start;
    logic       stage_wr;
    logic       clr_one;
    logic       clr_all;
    logic       do_commit;

    // Only bytes we actually asked for are accepted; a stray data_valid
    // (e.g. one left over across a reset) is ignored.
    assign byte_take  = data_valid && pending;
    assign is_digit   = (cmd_data >= 8'h30) && (cmd_data <= 8'h39);
    assign nn_calc    = 7'(d1) * 7'd10 + 7'(cmd_data[3:0]);
    assign cur_count  = count[bank_q];
    assign commit_row = RW'(bank_q) * RW'(CMD_DEPTH) + RW'(nn);

    assign rd_en = !rst && enable && data_ready && !pending && (state != S_COMMIT);
    assign busy  = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        err_set    = 1'b0;
        err_val    = 3'd0;
        lat_bank   = 1'b0;
        st_d1      = 1'b0;
        st_nn      = 1'b0;
        line_start = 1'b0;
        stage_wr   = 1'b0;
        clr_one    = 1'b0;
        clr_all    = 1'b0;
        do_commit  = 1'b0;

        if (state == S_COMMIT) begin
            // The line is already complete; let the row write finish.
            do_commit  = 1'b1;
            state_next = S_IDLE;
        end else if (!enable) begin
            // Abort: wait for the outstanding pop, drop its byte, go idle.
            if (state != S_IDLE && (!pending || data_valid)) begin
                state_next = S_IDLE;
            end
        end else if (byte_take) begin
            case (state)
                S_IDLE: begin
                    if (cmd_data == CH_CR || cmd_data == CH_LF) begin
                        state_next = S_IDLE;
                    end else if (is_digit) begin
                        st_d1      = 1'b1;
                        lat_bank   = 1'b1;
                        line_start = 1'b1;
                        state_next = S_ADDR_LO;
                    end else if (cmd_data == CH_C) begin
                        lat_bank   = 1'b1;
                        state_next = S_GOT_C;
                    end else begin
                        err_set    = 1'b1;
                        err_val    = ERR_ADDR;
                        state_next = S_DISCARD;
                    end
                end
                S_GOT_C: begin
                    if (cmd_data == CH_R) begin
                        clr_one    = 1'b1;
                        state_next = S_IDLE;
                    end else if (cmd_data == CH_A) begin
                        clr_all    = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        err_set    = 1'b1;
                        err_val    = ERR_CMD;
                        state_next = S_DISCARD;
                    end
                end
                S_ADDR_LO: begin
                    if (!is_digit) begin
                        err_set    = 1'b1;
                        err_val    = ERR_ADDR;
                        state_next = S_DISCARD;
                    end else if (nn_calc >= 7'(CMD_DEPTH)) begin
                        err_set    = 1'b1;
                        err_val    = (cur_count == CW'(CMD_DEPTH)) ? ERR_FULL : ERR_ADDR;
                        state_next = S_DISCARD;
                    end else if (nn_calc > 7'(cur_count)) begin
                        // Rows must be filled without gaps.
                        err_set    = 1'b1;
                        err_val    = ERR_ADDR;
                        state_next = S_DISCARD;
                    end else begin
                        st_nn      = 1'b1;
                        state_next = S_SPACE;
                    end
                end
                S_SPACE: begin
                    if (cmd_data == CH_SPACE) begin
                        state_next = S_TEXT;
                    end else begin
                        err_set    = 1'b1;
                        err_val    = ERR_SPACE;
                        state_next = S_DISCARD;
                    end
                end
                S_TEXT: begin
                    if (cmd_data == CH_CR) begin
                        if (len == '0) begin
                            err_set    = 1'b1;
                            err_val    = ERR_EMPTY;
                            state_next = S_IDLE;
                        end else begin
                            state_next = S_COMMIT;
                        end
                    end else if (len == LW'(CMD_WIDTH)) begin
                        err_set    = 1'b1;
                        err_val    = ERR_WIDE;
                        state_next = S_DISCARD;
                    end else begin
                        stage_wr = 1'b1;
                    end
                end
                S_DISCARD: begin
                    if (cmd_data == CH_LF) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= 1'b0;
            len         <= '0;
            stage       <= '0;
            bank_q      <= '0;
            d1          <= '0;
            nn          <= '0;
            cmd_written <= 1'b0;
            error_pulse <= 1'b0;
            error_code  <= 3'd0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                count[b] <= '0;
            end
        end else begin
            if (rd_en) begin
                pending <= 1'b1;
            end else if (data_valid) begin
                pending <= 1'b0;
            end

            cmd_written <= do_commit;
            error_pulse <= err_set;
            if (err_set) begin
                error_code <= err_val;
            end

            if (lat_bank) begin
                bank_q <= wr_bank;
            end
            if (st_d1) begin
                d1 <= cmd_data[3:0];
            end
            if (st_nn) begin
                nn <= nn_calc;
            end

            // Clearing the staging row at line start means a commit can
            // write the row verbatim with zero padding after the text.
            if (line_start) begin
                stage <= '0;
                len   <= '0;
            end else if (stage_wr) begin
                stage[JW'(len)] <= cmd_data;
                len             <= len + LW'(1);
            end

            if (clr_all) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    count[b] <= '0;
                end
            end else if (clr_one) begin
                count[bank_q] <= '0;
            end else if (do_commit && (7'(cur_count) == nn)) begin
                count[bank_q] <= cur_count + CW'(1);
            end
        end
    end

    // Table RAM has no reset; rows beyond a bank's count read back as zero.
    always_ff @(posedge clk) begin
        if (do_commit && !rst) begin
            mem[commit_row] <= stage;
        end
    end

    logic [AW-1:0] rd_off;
    logic [AW-1:0] rd_slot;
    logic [AW-1:0] rd_byte;
    logic [RW-1:0] rd_row;
    logic [7:0]    rd_next;

    always_comb begin
        rd_off  = rd_addr - AW'(1);
        rd_slot = rd_off / AW'(CMD_WIDTH);
        rd_byte = rd_off % AW'(CMD_WIDTH);
        rd_row  = RW'(rd_bank) * RW'(CMD_DEPTH) + RW'(rd_slot);
        rd_next = 8'h00;
        if (rd_addr == '0) begin
            rd_next = 8'(count[rd_bank]);
        end else if ((rd_addr <= AW'(CMD_DEPTH * CMD_WIDTH)) &&
                     (rd_slot < AW'(count[rd_bank]))) begin
            rd_next = mem[rd_row][JW'(rd_byte)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_cmd_memory_banked.sv
module tb_cmd_memory_banked;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       data_ready;
    logic       rd_en;
    logic       data_valid;
    logic [7:0] cmd_data;
    logic       wr_bank;
    logic       rd_bank;
    logic [9:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       cmd_written;
    logic       error_pulse;
    logic [2:0] error_code;

    int total = 0;
    int bad   = 0;
    int cw_cnt = 0;
    int ep_cnt = 0;

    logic [7:0] q[$];
    bit         popnow;

    cmd_memory_banked dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .data_ready  (data_ready),
        .rd_en       (rd_en),
        .data_valid  (data_valid),
        .cmd_data    (cmd_data),
        .wr_bank     (wr_bank),
        .rd_bank     (rd_bank),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .cmd_written (cmd_written),
        .error_pulse (error_pulse),
        .error_code  (error_code)
    );

    always #5 clk = ~clk;

    // RX FIFO model: a pop seen at a posedge returns its byte one cycle later.
    initial begin
        data_ready = 1'b0;
        data_valid = 1'b0;
        cmd_data   = 8'h00;
        forever begin
            @(negedge clk);
            popnow = rd_en;
            @(posedge clk);
            #1;
            if (popnow && q.size() > 0) begin
                data_valid = 1'b1;
                cmd_data   = q.pop_front();
            end else begin
                data_valid = 1'b0;
            end
            data_ready = (q.size() != 0);
        end
    end

    always @(negedge clk) begin
        if (cmd_written === 1'b1) cw_cnt++;
        if (error_pulse === 1'b1) ep_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endtask

    task automatic send_line(input string s);
        send(s);
        q.push_back(8'h0D);
        q.push_back(8'h0A);
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int n = 0; n < 4000 && !done; n++) begin
            @(negedge clk);
            if (q.size() == 0 && !data_valid && !rd_en && !busy) done = 1'b1;
        end
        chk(tag, done, 1);
    endtask

    task automatic wait_drain(input string tag);
        bit done = 1'b0;
        for (int n = 0; n < 4000 && !done; n++) begin
            @(negedge clk);
            if (q.size() == 0 && !data_valid && !rd_en) done = 1'b1;
        end
        chk(tag, done, 1);
    endtask

    task automatic chk_rd(input string tag, input logic b, input int a, input logic [7:0] exp);
        rd_bank = b;
        rd_addr = a[9:0];
        @(posedge clk);
        #1;
        chk(tag, rd_data, exp);
    endtask

    initial begin
        rst     = 1'b1;
        enable  = 1'b1;
        wr_bank = 1'b0;
        rd_bank = 1'b0;
        rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cw", cmd_written, 0);
        chk("rst_ep", error_pulse, 0);
        chk("rst_code", error_code, 0);
        chk("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        chk_rd("rst_cnt_b0", 0, 0, 8'd0);
        chk_rd("rst_cnt_b1", 1, 0, 8'd0);

        // basic commit
        send_line("00 AT");
        wait_idle("t1_idle");
        chk("t1_cw", cw_cnt, 1);
        chk("t1_ep", ep_cnt, 0);
        chk_rd("t1_cnt", 0, 0, 8'd1);
        chk_rd("t1_a1", 0, 1, 8'h41);
        chk_rd("t1_a2", 0, 2, 8'h54);
        chk_rd("t1_a3", 0, 3, 8'h00);
        chk_rd("t1_a32", 0, 32, 8'h00);
        chk_rd("t1_a33", 0, 33, 8'h00);

        // address gap, missing space, non-digit address
        send_line("05 X");
        wait_idle("t2a_idle");
        chk("t2a_ep", ep_cnt, 1);
        chk("t2a_code", error_code, 2);
        chk_rd("t2a_cnt", 0, 0, 8'd1);
        send_line("00AT");
        wait_idle("t2b_idle");
        chk("t2b_ep", ep_cnt, 2);
        chk("t2b_code", error_code, 3);
        chk_rd("t2b_a1", 0, 1, 8'h41);
        chk("t2b_cw", cw_cnt, 1);
        send_line("1X");
        wait_idle("t2c_idle");
        chk("t2c_ep", ep_cnt, 3);
        chk("t2c_code", error_code, 2);

        // width boundary and empty text
        send("00 ");
        for (int i = 0; i < 33; i++) q.push_back(8'h42);
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        wait_idle("t3a_idle");
        chk("t3a_ep", ep_cnt, 4);
        chk("t3a_code", error_code, 1);
        chk_rd("t3a_a1", 0, 1, 8'h41);
        chk("t3a_cw", cw_cnt, 1);
        send_line("00 0123456789ABCDEFGHIJKLMNOPQRSTUV");
        wait_idle("t3b_idle");
        chk("t3b_cw", cw_cnt, 2);
        chk("t3b_ep", ep_cnt, 4);
        chk_rd("t3b_cnt", 0, 0, 8'd1);
        chk_rd("t3b_a1", 0, 1, 8'h30);
        chk_rd("t3b_a32", 0, 32, 8'h56);
        chk_rd("t3b_a33", 0, 33, 8'h00);
        send_line("00 ");
        wait_idle("t3c_idle");
        chk("t3c_ep", ep_cnt, 5);
        chk("t3c_code", error_code, 6);
        chk_rd("t3c_a1", 0, 1, 8'h30);

        // second bank and clears
        wr_bank = 1'b1;
        send_line("00 B1");
        send_line("01 B2");
        wait_idle("t4a_idle");
        chk("t4a_cw", cw_cnt, 4);
        chk_rd("t4a_cnt1", 1, 0, 8'd2);
        chk_rd("t4a_b1_a33", 1, 33, 8'h42);
        chk_rd("t4a_b1_a34", 1, 34, 8'h32);
        chk_rd("t4a_cnt0", 0, 0, 8'd1);
        send_line("CR");
        wait_idle("t4b_idle");
        chk_rd("t4b_cnt1", 1, 0, 8'd0);
        chk_rd("t4b_cnt0", 0, 0, 8'd1);
        chk_rd("t4b_b1_a1", 1, 1, 8'h00);
        send_line("CX");
        wait_idle("t4c_idle");
        chk("t4c_ep", ep_cnt, 6);
        chk("t4c_code", error_code, 5);
        wr_bank = 1'b0;
        send_line("CA");
        wait_idle("t4d_idle");
        chk_rd("t4d_cnt0", 0, 0, 8'd0);
        chk_rd("t4d_cnt1", 1, 0, 8'd0);
        send_line("16 A");
        wait_idle("t4e_idle");
        chk("t4e_ep", ep_cnt, 7);
        chk("t4e_code", error_code, 2);

        // fill bank 0, full error, overwrite
        for (int i = 0; i < 16; i++) send_line($sformatf("%02d %c", i, 8'h61 + i));
        wait_idle("t5a_idle");
        chk("t5a_cw", cw_cnt, 20);
        chk_rd("t5a_cnt", 0, 0, 8'd16);
        chk_rd("t5a_a1", 0, 1, 8'h61);
        chk_rd("t5a_a481", 0, 481, 8'h70);
        chk_rd("t5a_a482", 0, 482, 8'h00);
        send_line("16 A");
        wait_idle("t5b_idle");
        chk("t5b_ep", ep_cnt, 8);
        chk("t5b_code", error_code, 4);
        send_line("03 B");
        wait_idle("t5c_idle");
        chk("t5c_cw", cw_cnt, 21);
        chk_rd("t5c_cnt", 0, 0, 8'd16);
        chk_rd("t5c_a97", 0, 97, 8'h42);
        chk_rd("t5c_a98", 0, 98, 8'h00);
        chk_rd("t5c_a512", 0, 512, 8'h00);
        chk_rd("t5c_a513", 0, 513, 8'h00);

        // enable dropped mid-line
        wr_bank = 1'b1;
        send("00 HE");
        wait_drain("t6a_drain");
        chk("t6a_busy_mid", busy, 1);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6a_busy", busy, 0);
        chk("t6a_cw", cw_cnt, 21);
        chk("t6a_ep", ep_cnt, 8);
        chk_rd("t6a_cnt1", 1, 0, 8'd0);
        enable = 1'b1;
        send_line("00 OK");
        wait_idle("t6b_idle");
        chk("t6b_cw", cw_cnt, 22);
        chk_rd("t6b_cnt1", 1, 0, 8'd1);
        chk_rd("t6b_a1", 1, 1, 8'h4F);
        chk_rd("t6b_a2", 1, 2, 8'h4B);
        chk_rd("t6b_a3", 1, 3, 8'h00);

        // reset mid-line
        send("01 ZZ");
        wait_drain("t6c_drain");
        chk("t6c_busy_mid", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6c_busy", busy, 0);
        chk("t6c_code", error_code, 0);
        chk_rd("t6c_cnt0", 0, 0, 8'd0);
        chk_rd("t6c_cnt1", 1, 0, 8'd0);
        chk("t6c_cw", cw_cnt, 22);
        wr_bank = 1'b0;
        send_line("00 AT");
        wait_idle("t6d_idle");
        chk("t6d_cw", cw_cnt, 23);
        chk_rd("t6d_cnt0", 0, 0, 8'd1);
        chk_rd("t6d_a1", 0, 1, 8'h41);

        // wr_bank change mid-line applies to the next line only
        wr_bank = 1'b1;
        send("00 Q");
        wait_drain("t6e_drain");
        wr_bank = 1'b0;
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        wait_idle("t6e_idle");
        chk("t6e_cw", cw_cnt, 24);
        chk_rd("t6e_cnt1", 1, 0, 8'd1);
        chk_rd("t6e_b1_a1", 1, 1, 8'h51);
        chk_rd("t6e_cnt0", 0, 0, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
